// File: rtl/fetch_buffer_pkg.sv
// Shared types for the fetch buffer: decoder entry layout and the packing helper.
// Entry = {exception[6:0], pc_next[31:0], pc[31:0], inst[31:0]}, bits 102:96 / 95:64 / 63:32 / 31:0.
package fetch_buffer_pkg;

    localparam int FB_WIDTH = 103;

    typedef struct packed {
        logic [6:0]  exc;
        logic [31:0] pc_next;
        logic [31:0] pc;
        logic [31:0] inst;
    } fb_entry_t;

    function automatic fb_entry_t fb_pack(
        input logic [6:0]  exc,
        input logic [31:0] pc_next,
        input logic [31:0] pc,
        input logic [31:0] inst
    );
        fb_entry_t e;
        e.exc     = exc;
        e.pc_next = pc_next;
        e.pc      = pc;
        e.inst    = inst;
        return e;
    endfunction

endpackage

// File: rtl/fetch_buffer_ram.sv
// DEPTH x FB_WIDTH register array, two write ports and two combinational read ports.
// Latency: write visible on reads the cycle after the edge. No backpressure; storage is not reset.
// Port 1 always targets the slot after port 0, so the two writes never collide.
module fetch_buffer_ram
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we0_i,
    input  logic [AW-1:0]       waddr0_i,
    input  logic [FB_WIDTH-1:0] wdata0_i,
    input  logic                we1_i,
    input  logic [AW-1:0]       waddr1_i,
    input  logic [FB_WIDTH-1:0] wdata1_i,
    input  logic [AW-1:0]       raddr0_i,
    output logic [FB_WIDTH-1:0] rdata0_o,
    input  logic [AW-1:0]       raddr1_i,
    output logic [FB_WIDTH-1:0] rdata1_o
);

    logic [FB_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we0_i) mem_q[waddr0_i] <= wdata0_i;
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fetch_buffer.sv
// Dual-issue FIFO from instruction fetch to the two decoder lanes.
// Latency: a push is visible on out_data one cycle later at the earliest (no bypass).
// Backpressure: in_ready needs 2 free entries in the registered count; same-cycle pops don't count.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [1:0]          in_valid,
    input  logic [6:0]          in_exc0,
    input  logic [31:0]         in_pc0,
    input  logic [31:0]         in_npc0,
    input  logic [31:0]         in_inst0,
    input  logic [6:0]          in_exc1,
    input  logic [31:0]         in_pc1,
    input  logic [31:0]         in_npc1,
    input  logic [31:0]         in_inst1,
    output logic                in_ready,
    output logic [FB_WIDTH-1:0] out_data0,
    output logic [FB_WIDTH-1:0] out_data1,
    output logic [1:0]          out_valid,
    input  logic [1:0]          out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] count_q, count_d;

    logic          push_fire;
    logic [1:0]    push_n;
    logic [1:0]    pop_n;
    fb_entry_t     wdata0, wdata1;
    logic [FB_WIDTH-1:0] rdata0, rdata1;

    assign in_ready     = (PW'(DEPTH) - count_q) >= PW'(2);
    assign out_valid[0] = count_q != '0;
    assign out_valid[1] = count_q >= PW'(2);

    // Illegal masks fall out naturally: slot1/lane1 only count when slot0/lane0 does.
    assign push_fire = in_ready & in_valid[0] & ~flush;
    assign push_n    = push_fire ? (in_valid[1] ? 2'd2 : 2'd1) : 2'd0;
    assign pop_n     = {1'b0, out_ready[0] & out_valid[0]}
                     + {1'b0, out_ready[1] & out_valid[1] & out_ready[0]};

    always_comb begin
        head_d  = head_q + PW'(pop_n);
        tail_d  = tail_q + PW'(push_n);
        count_d = count_q + PW'(push_n) - PW'(pop_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign wdata0 = fb_pack(in_exc0, in_npc0, in_pc0, in_inst0);
    assign wdata1 = fb_pack(in_exc1, in_npc1, in_pc1, in_inst1);

    fetch_buffer_ram #(.DEPTH(DEPTH)) u_ram (
        .clk      (clk),
        .we0_i    (push_fire),
        .waddr0_i (tail_q[AW-1:0]),
        .wdata0_i (wdata0),
        .we1_i    (push_fire & in_valid[1]),
        .waddr1_i (tail_q[AW-1:0] + AW'(1)),
        .wdata1_i (wdata1),
        .raddr0_i (head_q[AW-1:0]),
        .rdata0_o (rdata0),
        .raddr1_i (head_q[AW-1:0] + AW'(1)),
        .rdata1_o (rdata1)
    );

    assign out_data0 = out_valid[0] ? rdata0 : '0;
    assign out_data1 = out_valid[1] ? rdata1 : '0;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: vector table with hand-derived out_valid/in_ready, plus a scoreboard queue for entry data.
module tb_fetch_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [1:0]   in_valid;
    logic [6:0]   in_exc0, in_exc1;
    logic [31:0]  in_pc0, in_pc1, in_npc0, in_npc1, in_inst0, in_inst1;
    logic         in_ready;
    logic [102:0] out_data0, out_data1;
    logic [1:0]   out_valid;
    logic [1:0]   out_ready;

    fetch_buffer #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_exc0(in_exc0), .in_pc0(in_pc0), .in_npc0(in_npc0), .in_inst0(in_inst0),
        .in_exc1(in_exc1), .in_pc1(in_pc1), .in_npc1(in_npc1), .in_inst1(in_inst1),
        .in_ready(in_ready), .out_data0(out_data0), .out_data1(out_data1),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0]  pc_ctr;
    logic [102:0] sb[$];

    function automatic logic [102:0] mk(input logic [31:0] pc);
        logic [6:0] exc;
        exc = pc[8:2] ^ 7'h2a;
        return {exc, pc + 32'd4, pc, pc ^ 32'hdeadbeef};
    endfunction

    task automatic chk(input string nm, input logic [102:0] got, input logic [102:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // One cycle: drive inputs, check outputs mid-cycle, update the scoreboard, advance to edge+1.
    task automatic step(input logic [1:0] iv, input logic [1:0] ordy, input logic fl,
                        input logic [1:0] exp_ov, input logic exp_ir, input string nm);
        logic [102:0] e0, e1;
        int n, k;
        logic acc;
        e0 = mk(pc_ctr);
        e1 = mk(pc_ctr + 32'd4);
        in_valid = iv; out_ready = ordy; flush = fl;
        {in_exc0, in_npc0, in_pc0, in_inst0} = e0;
        {in_exc1, in_npc1, in_pc1, in_inst1} = e1;
        #2;
        chk({nm, ".out_valid"}, 103'(out_valid), 103'(exp_ov));
        chk({nm, ".in_ready"},  103'(in_ready),  103'(exp_ir));
        chk({nm, ".out_data0"}, out_data0, (sb.size() >= 1) ? sb[0] : 103'd0);
        chk({nm, ".out_data1"}, out_data1, (sb.size() >= 2) ? sb[1] : 103'd0);
        n = sb.size();
        if (fl) begin
            sb.delete();
        end else begin
            acc = ((8 - n) >= 2) && iv[0];
            k = 0;
            if (ordy[0] && n >= 1) k++;
            if (ordy[1] && ordy[0] && n >= 2) k++;
            repeat (k) void'(sb.pop_front());
            if (acc) begin
                sb.push_back(e0);
                pc_ctr += 32'd4;
                if (iv[1]) begin
                    sb.push_back(e1);
                    pc_ctr += 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] iv;
        logic [1:0] ordy;
        logic       fl;
        logic [1:0] exp_ov;
        logic       exp_ir;
        string      nm;
    } vec_t;

    vec_t vt[$];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 2'b00; out_ready = 2'b00;
        {in_exc0, in_npc0, in_pc0, in_inst0} = '0;
        {in_exc1, in_npc1, in_pc1, in_inst1} = '0;
        pc_ctr = 32'h1c000000;

        // idle after reset; dual push then dual pop
        vt.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b1, "reset_idle"});
        vt.push_back('{2'b11, 2'b00, 1'b0, 2'b00, 1'b1, "push2"});
        vt.push_back('{2'b00, 2'b11, 1'b0, 2'b11, 1'b1, "pop2"});
        vt.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b1, "empty_again"});
        // fill: in_ready holds while 2 entries are free, drops at 8
        vt.push_back('{2'b11, 2'b00, 1'b0, 2'b00, 1'b1, "fill_c0"});
        vt.push_back('{2'b11, 2'b00, 1'b0, 2'b11, 1'b1, "fill_c2"});
        vt.push_back('{2'b11, 2'b00, 1'b0, 2'b11, 1'b1, "fill_c4"});
        vt.push_back('{2'b11, 2'b00, 1'b0, 2'b11, 1'b1, "fill_c6"});
        vt.push_back('{2'b11, 2'b00, 1'b0, 2'b11, 1'b0, "full_push_ignored"});
        vt.push_back('{2'b00, 2'b01, 1'b0, 2'b11, 1'b0, "full_pop1"});
        vt.push_back('{2'b00, 2'b00, 1'b0, 2'b11, 1'b0, "c7_still_not_ready"});
        vt.push_back('{2'b00, 2'b01, 1'b0, 2'b11, 1'b0, "c7_pop1"});
        vt.push_back('{2'b00, 2'b00, 1'b0, 2'b11, 1'b1, "c6_ready"});
        // illegal masks act as no-ops
        vt.push_back('{2'b10, 2'b10, 1'b0, 2'b11, 1'b1, "illegal_masks"});
        vt.push_back('{2'b00, 2'b01, 1'b0, 2'b11, 1'b1, "c6_pop1"});
        // flush at count 5 with push and pop requested
        vt.push_back('{2'b11, 2'b11, 1'b1, 2'b11, 1'b1, "flush_c5"});
        vt.push_back('{2'b00, 2'b11, 1'b0, 2'b00, 1'b1, "after_flush"});
        vt.push_back('{2'b01, 2'b00, 1'b0, 2'b00, 1'b1, "push1_post_flush"});
        vt.push_back('{2'b00, 2'b01, 1'b0, 2'b01, 1'b1, "fresh_entry_only"});
        vt.push_back('{2'b00, 2'b00, 1'b0, 2'b00, 1'b1, "drained"});

        #12 rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vt[i]) step(vt[i].iv, vt[i].ordy, vt[i].fl, vt[i].exp_ov, vt[i].exp_ir, vt[i].nm);

        // wrap-around: mixed single/dual pushes and pops across many pointer laps
        for (int i = 0; i < 80; i++) begin
            logic [1:0] iv, ordy;
            int sel;
            sel = $urandom_range(0, 2);
            iv = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
            sel = $urandom_range(0, 2);
            ordy = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
            step(iv, ordy, 1'b0,
                 {sb.size() >= 2, sb.size() >= 1}, (8 - sb.size()) >= 2, "wrap_mix");
        end

        // drain, then build count=3 for the asynchronous reset
        while (sb.size() > 0)
            step(2'b00, 2'b11, 1'b0, {sb.size() >= 2, 1'b1}, (8 - sb.size()) >= 2, "drain");
        step(2'b11, 2'b00, 1'b0, 2'b00, 1'b1, "pre_rst_push2");
        step(2'b01, 2'b00, 1'b0, 2'b11, 1'b1, "pre_rst_push1");
        chk("exc_field", 103'(out_data0[102:96]), 103'(sb[0][102:96]));
        chk("pc_field",  103'(out_data0[63:32]),  103'(sb[0][63:32]));
        in_valid = 2'b00;
        #2 rst = 1'b1;
        #1;
        chk("async_rst.out_valid", 103'(out_valid), 103'(2'b00));
        chk("async_rst.in_ready",  103'(in_ready),  103'(1'b1));
        chk("async_rst.out_data0", out_data0, 103'd0);
        sb.delete();
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        step(2'b11, 2'b00, 1'b0, 2'b00, 1'b1, "post_rst_push2");
        step(2'b00, 2'b11, 1'b0, 2'b11, 1'b1, "post_rst_pop2");
        step(2'b00, 2'b00, 1'b0, 2'b00, 1'b1, "post_rst_empty");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
